// File: rtl/rv_g_pkg.sv
// Shared fetch-path definitions for the rv_g core: PC width, NOP encoding
// and the packed fetch-queue entry.
package rv_g_pkg;

  localparam int unsigned XLEN = 64;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     code;
    logic            err;
  } fetch_entry_t;

endpackage

// File: rtl/rv_g_ifq.sv
// Instruction fetch queue: DEPTH-entry FIFO between fetch and decode with
// one-cycle first-word latency, flush on redirect and NOP fill when empty.
module rv_g_ifq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = rv_g_pkg::XLEN
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [31:0]                code_i,
  input  logic                       err_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [XLEN-1:0]            pc_o,
  output logic [31:0]                code_o,
  output logic                       err_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);
  import rv_g_pkg::*;

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);

  // Entry layout follows this instance's XLEN, which may differ from the core default.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     code;
    logic            err;
  } ifq_entry_t;

  ifq_entry_t      mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            pop_s;
  ifq_entry_t      head_s;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[IW-1:0] == rd_ptr_r[IW-1:0]) &&
                   (wr_ptr_r[IW] != rd_ptr_r[IW]);

  assign ready_o = !full_s;
  assign valid_o = !empty_s;
  assign count_o = wr_ptr_r - rd_ptr_r;

  assign push_s = valid_i && ready_o && !flush_i;
  assign pop_s  = valid_o && ready_i && !flush_i;

  // Pointer state; flush overrides any push/pop in the same cycle.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else if (flush_i) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Entry storage, written at the tail; contents are don't-care until pushed.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r[IW-1:0]] <= '{pc: pc_i, code: code_i, err: err_i};
    end
  end

  // Head read; an empty queue presents a harmless NOP to the decoder.
  always_comb begin
    head_s = mem_r[rd_ptr_r[IW-1:0]];
    pc_o   = '0;
    code_o = NOP_INSN;
    err_o  = 1'b0;
    if (valid_o) begin
      pc_o   = head_s.pc;
      code_o = head_s.code;
      err_o  = head_s.err;
    end else begin
      pc_o   = '0;
      code_o = NOP_INSN;
      err_o  = 1'b0;
    end
  end

endmodule
